// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the RV32 fetch PC, issues one outstanding word read to
// instruction memory (req/ack), buffers returned words in a QDEPTH-entry FIFO
// and presents {pc, instruction} to decode over valid/ready. Redirects flush
// the FIFO and drop any response that is still in flight.
// Optional build macro FETCH_STALL_CNT_EN adds a saturating stall_cnt output
// that counts cycles with imem_req && !imem_ack.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2  // 2 or 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int          PW       = (QDEPTH == 4) ? 2 : 1;
  localparam logic [PW:0] QDEPTH_C = (PW+1)'(QDEPTH);

  typedef enum logic {
    S_FETCH   = 1'b0,
    S_DISCARD = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   target_q, target_d;
  logic          req_en_q;

  logic [31:0]   q_pc   [QDEPTH];
  logic [31:0]   q_data [QDEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;

  logic          do_enq;
  logic          do_deq;
  logic          flush;
  logic [31:0]   redirect_al;

  assign redirect_al = redirect_pc & 32'hFFFF_FFFC;

  // Decode-side handshake: redirect masks the head so nothing is consumed
  // on the flush cycle.
  assign inst_valid = (count_q != '0) && !redirect_valid;
  assign do_deq     = inst_valid && inst_ready;
  assign inst_pc    = (count_q != '0) ? q_pc[rd_ptr_q]   : 32'h0;
  assign inst_data  = (count_q != '0) ? q_data[rd_ptr_q] : 32'h0;

  // Fetch FSM: request generation, PC update and redirect/discard handling.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned and no latch is inferred.
    state_d   = state_q;
    pc_d      = pc_q;
    target_d  = target_q;
    imem_req  = 1'b0;
    imem_addr = pc_q;
    do_enq    = 1'b0;
    flush     = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = req_en_q && (count_q < QDEPTH_C);
        if (redirect_valid) begin
          flush = 1'b1;
          if (imem_req && !imem_ack) begin
            // Request is already on the bus; it must complete before the
            // new PC may be presented.
            target_d = redirect_al;
            state_d  = S_DISCARD;
          end else begin
            pc_d = redirect_al;
          end
        end else if (imem_req && imem_ack) begin
          do_enq = 1'b1;
          pc_d   = pc_q + 32'd4;
        end
      end
      S_DISCARD: begin
        imem_req = 1'b1;
        if (redirect_valid) begin
          flush    = 1'b1;
          target_d = redirect_al;
        end
        if (imem_ack) begin
          pc_d    = redirect_valid ? redirect_al : target_q;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      target_q <= RESET_PC;
      req_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      target_q <= target_d;
      req_en_q <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; flush wins over enqueue/dequeue.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_enq) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_deq) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_enq, do_deq})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; count_q gates every read, and the outputs
    // are forced to zero while the queue is empty.
    if (do_enq) begin
      q_pc[wr_ptr_q]   <= pc_q;
      q_data[wr_ptr_q] <= imem_rdata;
    end
  end

`ifdef FETCH_STALL_CNT_EN
  // Saturating count of cycles a request waits for memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'h0;
    end else if (imem_req && !imem_ack && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
